rv_fetch_aligner: RTL and testbench

Splits fetch packets into individual RISC-V instructions (16-bit RVC or 32-bit) and delivers them one per cycle to the predecode classifier. It sits between the instruction-fetch packet buffer and the per-instruction predecoder, and produces the exact `instr[31:0]` stream that the classifier consumes. It tracks the halfword pointer within the current packet, and it carries the low half of a 32-bit instruction that straddles two packets.

---
 rtl/rv_fetch_aligner_if.sv | 32 +++
 rtl/rv_fetch_aligner.sv | 135 +++++++++++++
 tb/tb_rv_fetch_aligner.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_aligner_if.sv
// Handshake bundle between the fetch packet buffer, the aligner and the predecoder.
// The master side feeds packets and accepts instructions; the slave side is the aligner.
interface rv_fetch_aligner_if #(
    parameter int FETCH_HW = 8,
    parameter int PC_W     = 48
);
    localparam int PTR_W = $clog2(FETCH_HW);

    logic                   in_valid;
    logic                   in_ready;
    logic [16*FETCH_HW-1:0] in_data;
    logic [PC_W-1:0]        in_pc;
    logic [PTR_W-1:0]       in_start;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_instr;
    logic [PC_W-1:0]        out_pc;
    logic                   out_is_rvc;
    logic                   out_straddle;
    logic                   out_bad_len;

    modport master (
        output in_valid, in_data, in_pc, in_start, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_is_rvc, out_straddle, out_bad_len
    );

    modport slave (
        input  in_valid, in_data, in_pc, in_start, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_is_rvc, out_straddle, out_bad_len
    );
endinterface

// File: rtl/rv_fetch_aligner.sv
// Splits fetch packets into 16/32-bit RISC-V instructions, one per cycle, and
// stitches 32-bit instructions that straddle two sequential packets.
module rv_fetch_aligner #(
    parameter int FETCH_HW = 8,
    parameter int PC_W     = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_fetch_aligner_if.slave bus
);
    localparam int PTR_W = $clog2(FETCH_HW);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FETCH_HW - 1);
    localparam logic [PTR_W-1:0] PEN_PTR  = PTR_W'(FETCH_HW - 2);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_CARRY  = 2'd2;

    logic [1:0]       state_reg;
    logic [15:0]      pkt_buf_reg [FETCH_HW];
    logic [PC_W-1:0]  buf_pc_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [15:0]      carry_hw_reg;
    logic [PC_W-1:0]  carry_pc_reg;
    logic             carry_valid_reg;

    logic [15:0]      in_hw [FETCH_HW];

    generate
        for (genvar gi = 0; gi < FETCH_HW; gi++) begin : g_unpack
            assign in_hw[gi] = bus.in_data[16*gi +: 16];
        end
    endgenerate

    logic             active;
    logic             straddle_pend;
    logic [PTR_W-1:0] ptr_inc1;
    logic [15:0]      lo_hw;
    logic [15:0]      hi_hw;
    logic             len16;
    logic             at_last;
    logic             complete;
    logic             fire;
    logic             spill;
    logic             consume_last;
    logic             accept;
    logic             seq_cont;
    logic [PC_W-1:0]  cur_pc;
    logic [31:0]      instr_sel;

    assign active   = (state_reg == ST_ACTIVE);
    // In ACTIVE a still-valid carry means the next instruction is the stitched one.
    assign straddle_pend = active && carry_valid_reg;
    assign ptr_inc1 = ptr_reg + PTR_W'(1);

    assign lo_hw = straddle_pend ? carry_hw_reg   : pkt_buf_reg[ptr_reg];
    assign hi_hw = straddle_pend ? pkt_buf_reg[0] : pkt_buf_reg[ptr_inc1];

    assign len16    = (lo_hw[1:0] != 2'b11);
    assign at_last  = (ptr_reg == LAST_PTR);
    assign complete = straddle_pend || len16 || !at_last;

    assign fire  = bus.out_valid && bus.out_ready;
    assign spill = active && !bus.flush && !complete;

    assign consume_last = fire && !straddle_pend &&
                          (len16 ? at_last : (ptr_reg == PEN_PTR));

    assign accept   = bus.in_valid && bus.in_ready;
    assign seq_cont = (state_reg == ST_CARRY) && (bus.in_start == '0) &&
                      (bus.in_pc == carry_pc_reg + PC_W'(2));

    assign cur_pc    = straddle_pend ? carry_pc_reg
                                     : buf_pc_reg + PC_W'({ptr_reg, 1'b0});
    assign instr_sel = len16 ? {16'b0, lo_hw} : {hi_hw, lo_hw};

    assign bus.in_ready = rst_n && !bus.flush &&
                          ((state_reg == ST_EMPTY) || (state_reg == ST_CARRY) || consume_last);

    assign bus.out_valid    = active && !bus.flush && complete;
    // Fields read as zero whenever no packet is held so reset shows clean outputs.
    assign bus.out_instr    = active ? instr_sel : 32'b0;
    assign bus.out_pc       = active ? cur_pc : '0;
    assign bus.out_is_rvc   = active && len16;
    assign bus.out_straddle = straddle_pend;
    assign bus.out_bad_len  = active && (lo_hw[4:0] == 5'b11111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_EMPTY;
            buf_pc_reg      <= '0;
            ptr_reg         <= '0;
            carry_hw_reg    <= '0;
            carry_pc_reg    <= '0;
            carry_valid_reg <= 1'b0;
            for (int i = 0; i < FETCH_HW; i++) begin
                pkt_buf_reg[i] <= '0;
            end
        end else if (bus.flush) begin
            state_reg       <= ST_EMPTY;
            ptr_reg         <= '0;
            carry_valid_reg <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < FETCH_HW; i++) begin
                pkt_buf_reg[i] <= in_hw[i];
            end
            buf_pc_reg <= bus.in_pc;
            state_reg  <= ST_ACTIVE;
            if (seq_cont) begin
                ptr_reg         <= '0;
                carry_valid_reg <= 1'b1;
            end else begin
                ptr_reg         <= bus.in_start;
                carry_valid_reg <= 1'b0;
            end
        end else if (spill) begin
            // Low half of a 32-bit instruction at the packet end waits for the next packet.
            carry_hw_reg    <= lo_hw;
            carry_pc_reg    <= cur_pc;
            carry_valid_reg <= 1'b1;
            ptr_reg         <= '0;
            state_reg       <= ST_CARRY;
        end else if (fire) begin
            if (straddle_pend) begin
                ptr_reg         <= PTR_W'(1);
                carry_valid_reg <= 1'b0;
            end else if (consume_last) begin
                ptr_reg   <= '0;
                state_reg <= ST_EMPTY;
            end else begin
                ptr_reg <= len16 ? ptr_inc1 : ptr_reg + PTR_W'(2);
            end
        end
    end
endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Directed bench for rv_fetch_aligner: RVC/32-bit splitting, straddle, redirect,
// backpressure, flush and reset behaviour against hand-computed values.
module tb_rv_fetch_aligner;
    localparam int FH = 8;
    localparam int PW = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_fetch_aligner_if #(.FETCH_HW(FH), .PC_W(PW)) bus ();

    rv_fetch_aligner #(.FETCH_HW(FH), .PC_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] hws [FH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic fill_hws(input logic [15:0] v);
        for (int k = 0; k < FH; k++) hws[k] = v;
    endtask

    task automatic drive_pkt(input logic [47:0] pc, input logic [2:0] start);
        for (int k = 0; k < FH; k++) bus.in_data[16*k +: 16] = hws[k];
        bus.in_pc    = pc;
        bus.in_start = start;
        bus.in_valid = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] instr, input logic [47:0] pc,
                              input logic rvc, input logic str, input logic bl);
        $display("out %s: pc=%h instr=%h rvc=%0b straddle=%0b bad_len=%0b", tag,
                 bus.out_pc, bus.out_instr, bus.out_is_rvc, bus.out_straddle, bus.out_bad_len);
        chk({tag, ".valid"},    64'(bus.out_valid),    64'd1);
        chk({tag, ".instr"},    64'(bus.out_instr),    64'(instr));
        chk({tag, ".pc"},       64'(bus.out_pc),       64'(pc));
        chk({tag, ".rvc"},      64'(bus.out_is_rvc),   64'(rvc));
        chk({tag, ".straddle"}, 64'(bus.out_straddle), 64'(str));
        chk({tag, ".bad_len"},  64'(bus.out_bad_len),  64'(bl));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_pc     = '0;
        bus.in_start  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_instr",     64'(bus.out_instr), 64'd0);
        chk("rst_pc",        64'(bus.out_pc),    64'd0);
        chk("rst_straddle",  64'(bus.out_straddle), 64'd0);

        rst_n = 1'b1;
        step;
        chk("ready_after_rst", 64'(bus.in_ready),  64'd1);
        chk("idle_out_valid",  64'(bus.out_valid), 64'd0);

        // Eight RVC halfwords, then four addi back-to-back with no bubble.
        for (int k = 0; k < FH; k++) hws[k] = 16'h0001 | 16'(k << 8);
        drive_pkt(48'h1000, 3'd0);
        step;
        bus.in_valid = 1'b0;
        for (int i = 0; i < FH; i++) begin
            settle;
            expect_out($sformatf("rvc%0d", i), 32'h0001 | 32'(i << 8), 48'h1000 + 48'(2*i),
                       1'b1, 1'b0, 1'b0);
            chk($sformatf("rvc%0d.in_ready", i), 64'(bus.in_ready), 64'(i == FH-1));
            if (i == FH-1) begin
                for (int k = 0; k < FH; k += 2) begin
                    hws[k]   = 16'h0013;
                    hws[k+1] = 16'h0000;
                end
                drive_pkt(48'h1000, 3'd0);
            end
            step;
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            settle;
            expect_out($sformatf("addi%0d", j), 32'h00000013, 48'h1000 + 48'(4*j),
                       1'b0, 1'b0, 1'b0);
            chk($sformatf("addi%0d.in_ready", j), 64'(bus.in_ready), 64'(j == 3));
            step;
        end
        settle;
        chk("drained_out_valid", 64'(bus.out_valid), 64'd0);

        // Straddle across sequential packets.
        fill_hws(16'h0001);
        hws[7] = 16'h0513;
        drive_pkt(48'h2000, 3'd6);
        step;
        bus.in_valid = 1'b0;
        settle;
        expect_out("strA6", 32'h00000001, 48'h200C, 1'b1, 1'b0, 1'b0);
        step;
        settle;
        chk("spill_out_valid", 64'(bus.out_valid), 64'd0);
        chk("spill_in_ready",  64'(bus.in_ready),  64'd0);
        step;
        settle;
        chk("carry_in_ready",  64'(bus.in_ready),  64'd1);
        chk("carry_out_valid", 64'(bus.out_valid), 64'd0);
        fill_hws(16'h0001);
        hws[0] = 16'h0000;
        drive_pkt(48'h2010, 3'd0);
        step;
        bus.in_valid = 1'b0;
        settle;
        expect_out("straddle", 32'h00000513, 48'h200E, 1'b0, 1'b1, 1'b0);
        step;
        settle;
        expect_out("strB1", 32'h00000001, 48'h2012, 1'b1, 1'b0, 1'b0);

        // Flush together with a presented packet while ACTIVE.
        fill_hws(16'h0001);
        bus.flush = 1'b1;
        drive_pkt(48'h9000, 3'd0);
        settle;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready",  64'(bus.in_ready),  64'd0);
        step;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        settle;
        chk("postflush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("postflush_in_ready",  64'(bus.in_ready),  64'd1);
        hws[3] = 16'h0041;
        drive_pkt(48'h4000, 3'd3);
        step;
        bus.in_valid = 1'b0;
        settle;
        expect_out("start3", 32'h00000041, 48'h4006, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        step;
        bus.flush = 1'b0;

        // Carry broken by a non-sequential packet.
        fill_hws(16'h0001);
        hws[7] = 16'h0013;
        drive_pkt(48'h5000, 3'd7);
        step;
        bus.in_valid = 1'b0;
        settle;
        chk("redir_spill_valid", 64'(bus.out_valid), 64'd0);
        step;
        settle;
        chk("redir_carry_ready", 64'(bus.in_ready), 64'd1);
        fill_hws(16'h0001);
        hws[2] = 16'h0005;
        hws[3] = 16'h001F;
        hws[4] = 16'h0000;
        drive_pkt(48'h3000, 3'd2);
        step;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Backpressure holds the pending instruction.
        for (int c = 0; c < 5; c++) begin
            settle;
            expect_out($sformatf("hold%0d", c), 32'h00000005, 48'h3004, 1'b1, 1'b0, 1'b0);
            chk($sformatf("hold%0d.in_ready", c), 64'(bus.in_ready), 64'd0);
            step;
        end
        bus.out_ready = 1'b1;
        settle;
        expect_out("release", 32'h00000005, 48'h3004, 1'b1, 1'b0, 1'b0);
        step;
        settle;
        expect_out("badlen", 32'h0000001F, 48'h3006, 1'b0, 1'b0, 1'b1);

        // Reset mid-packet drops everything at once.
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("midrst_instr",     64'(bus.out_instr), 64'd0);
        step;
        chk("midrst_hold_valid", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
